// File: rtl/tri_fetch_pipe.sv
// tri_fetch_pipe: walks the transformed-vertex result memory and hands one
// triangle (list or strip topology) plus its colour at a time to the rasteriser.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   start, strip, count   frame request; strip/count latched when start is taken
//   done                  high while idle
//   mem_read_addr/data    vertex word memory, data valid one cycle after address
//   mem_col_addr/data     colour memory indexed by triangle, same latency
//   ax..cz, colour        registered triangle handed to the rasteriser
//   draw_en, draw_done    one-cycle triangle-valid pulse / rasteriser completion
module tri_fetch_pipe #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned COLOUR_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    strip,
    input  logic [WIDTH-1:0]        count,
    output logic                    done,
    output logic [WIDTH-1:0]        mem_read_addr,
    input  logic [WIDTH-1:0]        mem_read_data,
    output logic [WIDTH-1:0]        mem_col_addr,
    input  logic [COLOUR_WIDTH-1:0] mem_col_data,
    output logic [WIDTH-1:0]        ax,
    output logic [WIDTH-1:0]        ay,
    output logic [WIDTH-1:0]        az,
    output logic [WIDTH-1:0]        bx,
    output logic [WIDTH-1:0]        by,
    output logic [WIDTH-1:0]        bz,
    output logic [WIDTH-1:0]        cx,
    output logic [WIDTH-1:0]        cy,
    output logic [WIDTH-1:0]        cz,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    draw_en,
    input  logic                    draw_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_DRAW,
        S_WAIT_DRAW
    } state_t;

    // Slots 0..8 are a.x a.y a.z b.x b.y b.z c.x c.y c.z; strip refills only c.
    localparam int unsigned SLOT_W = 4;
    localparam logic [SLOT_W-1:0] SLOT_LIST_FIRST  = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_STRIP_FIRST = SLOT_W'(6);
    localparam logic [SLOT_W-1:0] SLOT_FINAL       = SLOT_W'(8);

    state_t            state;
    logic              strip_q;
    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  wa;
    logic [WIDTH-1:0]  ti;
    logic [SLOT_W-1:0] slot;
    logic              rd_valid;
    logic [SLOT_W-1:0] rd_slot;

    assign mem_read_addr = wa;
    assign mem_col_addr  = ti;

    // Control FSM with read-return pipeline: the slot of each issued read
    // travels one cycle alongside it so the returning word lands in place.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            strip_q  <= 1'b0;
            count_q  <= '0;
            wa       <= '0;
            ti       <= '0;
            slot     <= '0;
            rd_valid <= 1'b0;
            rd_slot  <= '0;
            ax       <= '0;
            ay       <= '0;
            az       <= '0;
            bx       <= '0;
            by       <= '0;
            bz       <= '0;
            cx       <= '0;
            cy       <= '0;
            cz       <= '0;
            colour   <= '0;
            draw_en  <= 1'b0;
            done     <= 1'b1;
        end else begin
            draw_en  <= 1'b0;
            rd_valid <= 1'b0;

            if (rd_valid) begin
                case (rd_slot)
                    SLOT_W'(0): ax <= mem_read_data;
                    SLOT_W'(1): ay <= mem_read_data;
                    SLOT_W'(2): az <= mem_read_data;
                    SLOT_W'(3): bx <= mem_read_data;
                    SLOT_W'(4): by <= mem_read_data;
                    SLOT_W'(5): bz <= mem_read_data;
                    SLOT_W'(6): cx <= mem_read_data;
                    SLOT_W'(7): cy <= mem_read_data;
                    SLOT_W'(8): cz <= mem_read_data;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        strip_q <= strip;
                        count_q <= count;
                        wa      <= '0;
                        ti      <= '0;
                        slot    <= SLOT_LIST_FIRST;
                        if (count != '0) begin
                            state <= S_FETCH;
                            done  <= 1'b0;
                        end
                    end
                end

                S_FETCH: begin
                    rd_valid <= 1'b1;
                    rd_slot  <= slot;
                    wa       <= wa + WIDTH'(1);
                    slot     <= slot + SLOT_W'(1);
                    if (slot == SLOT_FINAL) begin
                        state <= S_LAST;
                    end
                end

                // Final word arrives this cycle through the pipeline above.
                S_LAST: begin
                    colour  <= mem_col_data;
                    draw_en <= 1'b1;
                    state   <= S_DRAW;
                end

                S_DRAW: begin
                    state <= S_WAIT_DRAW;
                end

                S_WAIT_DRAW: begin
                    if (draw_done) begin
                        if (ti + WIDTH'(1) == count_q) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            ti    <= ti + WIDTH'(1);
                            state <= S_FETCH;
                            if (strip_q) begin
                                slot <= SLOT_STRIP_FIRST;
                                ax   <= bx;
                                ay   <= by;
                                az   <= bz;
                                bx   <= cx;
                                by   <= cy;
                                bz   <= cz;
                            end else begin
                                slot <= SLOT_LIST_FIRST;
                            end
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_fetch_pipe.sv
// Directed bench for tri_fetch_pipe: word memory k=k, colour[i]=i+5,
// rasteriser acknowledges 4 cycles after each draw_en.
module tb_tri_fetch_pipe;

    logic        clock;
    logic        reset;
    logic        start;
    logic        strip;
    logic [31:0] count;
    logic        done;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_col_addr;
    logic [2:0]  mem_col_data;
    logic [31:0] ax, ay, az, bx, by, bz, cx, cy, cz;
    logic [2:0]  colour;
    logic        draw_en;
    logic        draw_done;

    int vectors;
    int miscompares;

    // Per-frame observations
    logic [31:0] tri_v [8][9];
    logic [2:0]  tri_col [8];
    logic [31:0] hold_ax [8];
    logic [2:0]  hold_col [8];
    int          draw_cyc [8];
    int          d_cyc [8];
    int          n_draws;
    int          n_dones;
    int          done_fall;
    int          done_rise;
    logic [31:0] addr_c1;
    logic [31:0] addr_c2;

    tri_fetch_pipe #(.WIDTH(32), .COLOUR_WIDTH(3)) dut (
        .clock(clock), .reset(reset), .start(start), .strip(strip), .count(count),
        .done(done), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_col_addr(mem_col_addr), .mem_col_data(mem_col_data),
        .ax(ax), .ay(ay), .az(az), .bx(bx), .by(by), .bz(bz),
        .cx(cx), .cy(cy), .cz(cz), .colour(colour),
        .draw_en(draw_en), .draw_done(draw_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memories: word k holds k, colour i holds i+5.
    always @(posedge clock) begin
        mem_read_data <= mem_read_addr;
        mem_col_data  <= 3'(mem_col_addr + 32'd5);
    end

    // Run one frame from a start pulse until done rises; cycle 1 is the first
    // cycle after start is sampled. With spur set, draw_done is held high
    // outside the wait window and start is re-pulsed during each wait.
    task automatic run_frame(input logic s, input logic [31:0] n, input bit spur, input int budget);
        int  pend_d;
        bit  busy;
        n_draws   = 0;
        n_dones   = 0;
        done_fall = -1;
        done_rise = -1;
        addr_c1   = '1;
        addr_c2   = '1;
        @(negedge clock);
        start = 1'b1; strip = s; count = n;
        @(posedge clock);
        @(negedge clock);
        start  = 1'b0;
        pend_d = -1;
        busy   = spur;
        for (int rel = 1; rel <= budget; rel++) begin
            if (rel > 1) @(negedge clock);
            strip = s;
            start = 1'b0;
            if (rel == 1) addr_c1 = mem_read_addr;
            if (rel == 2) addr_c2 = mem_read_addr;
            if (!done && done_fall < 0) done_fall = rel;
            if (done && done_fall >= 0 && done_rise < 0) done_rise = rel;
            if (draw_en && n_draws < 8) begin
                tri_v[n_draws] = '{ax, ay, az, bx, by, bz, cx, cy, cz};
                tri_col[n_draws]  = colour;
                draw_cyc[n_draws] = rel;
                pend_d  = rel + 4;
                busy    = 1'b0;
                n_draws++;
            end
            if (rel == pend_d && n_dones < 8) begin
                hold_ax[n_dones]  = ax;
                hold_col[n_dones] = colour;
                d_cyc[n_dones]    = rel;
                n_dones++;
                pend_d    = -1;
                draw_done = 1'b1;
                busy      = spur;
            end else begin
                draw_done = busy;
            end
            if (spur && n_draws > 0 && rel == draw_cyc[n_draws-1] + 2) begin
                start = 1'b1;
                strip = ~s;
            end
            if (done_rise >= 0) break;
        end
        @(negedge clock);
        draw_done = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (done !== 1'b1 || draw_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: done=%b draw_en=%b expected done=1 draw_en=0", done, draw_en);
        end
        vectors++;
        if (mem_read_addr !== 32'd0 || mem_col_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_addr: read=%0d col=%0d expected 0 0", mem_read_addr, mem_col_addr);
        end
        vectors++;
        if ({ax, ay, az, bx, by, bz, cx, cy, cz} !== '0 || colour !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_tri: ax=%0d cz=%0d colour=%0d expected all 0", ax, cz, colour);
        end
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_done: got %b expected 1", done);
        end
    endtask

    task automatic test_reset_mid_fetch;
        @(negedge clock);
        start = 1'b1; strip = 1'b0; count = 32'd2;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (done !== 1'b0 || mem_read_addr !== 32'd3) begin
            miscompares++;
            $display("FAIL midfetch_pre: done=%b addr=%0d expected 0 3", done, mem_read_addr);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b1 || draw_en !== 1'b0 || mem_read_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL midfetch_abort: done=%b draw_en=%b addr=%0d expected 1 0 0",
                     done, draw_en, mem_read_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        run_frame(1'b0, 32'd1, 1'b0, 100);
        vectors++;
        if (addr_c1 !== 32'd0 || addr_c2 !== 32'd1) begin
            miscompares++;
            $display("FAIL restart_addr: c1=%0d c2=%0d expected 0 1", addr_c1, addr_c2);
        end
        vectors++;
        if (n_draws !== 1 || draw_cyc[0] !== 11 || done_rise !== 16) begin
            miscompares++;
            $display("FAIL restart_timing: draws=%0d draw_cyc=%0d rise=%0d expected 1 11 16",
                     n_draws, draw_cyc[0], done_rise);
        end
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (tri_v[0][i] !== 32'(i)) begin
                miscompares++;
                $display("FAIL restart_word%0d: got %0d expected %0d", i, tri_v[0][i], i);
            end
        end
    endtask

    task automatic test_list;
        run_frame(1'b0, 32'd2, 1'b0, 200);
        vectors++;
        if (done_rise < 0) begin
            miscompares++;
            $display("FAIL list_timeout: done never rose, draws=%0d expected 2", n_draws);
        end
        vectors++;
        if (done_fall !== 1 || n_draws !== 2) begin
            miscompares++;
            $display("FAIL list_count: fall=%0d draws=%0d expected 1 2", done_fall, n_draws);
        end
        vectors++;
        if (draw_cyc[0] !== 11 || draw_cyc[1] !== d_cyc[0] + 11 || done_rise !== d_cyc[1] + 1) begin
            miscompares++;
            $display("FAIL list_timing: draw0=%0d draw1=%0d rise=%0d expected 11 26 31",
                     draw_cyc[0], draw_cyc[1], done_rise);
        end
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 9; i++) begin
                vectors++;
                if (tri_v[t][i] !== 32'(9*t + i)) begin
                    miscompares++;
                    $display("FAIL list_tri%0d_word%0d: got %0d expected %0d", t, i, tri_v[t][i], 9*t + i);
                end
            end
            vectors++;
            if (tri_col[t] !== 3'(t + 5) || hold_col[t] !== 3'(t + 5) || hold_ax[t] !== 32'(9*t)) begin
                miscompares++;
                $display("FAIL list_col%0d: colour=%0d held=%0d held_ax=%0d expected %0d %0d %0d",
                         t, tri_col[t], hold_col[t], hold_ax[t], t + 5, t + 5, 9*t);
            end
        end
        vectors++;
        if (mem_read_addr !== 32'd18) begin
            miscompares++;
            $display("FAIL list_reads: got %0d expected 18", mem_read_addr);
        end
    endtask

    task automatic test_strip(input bit spur);
        run_frame(1'b1, 32'd3, spur, 200);
        vectors++;
        if (done_rise < 0 || n_draws !== 3) begin
            miscompares++;
            $display("FAIL strip_count(spur=%0d): rise=%0d draws=%0d expected >0 3", spur, done_rise, n_draws);
        end
        vectors++;
        if (draw_cyc[0] !== 11 || draw_cyc[1] !== 20 || draw_cyc[2] !== 29 || done_rise !== 34) begin
            miscompares++;
            $display("FAIL strip_timing(spur=%0d): draws=%0d,%0d,%0d rise=%0d expected 11,20,29 34",
                     spur, draw_cyc[0], draw_cyc[1], draw_cyc[2], done_rise);
        end
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 9; i++) begin
                vectors++;
                if (tri_v[t][i] !== 32'(3*t + i)) begin
                    miscompares++;
                    $display("FAIL strip_tri%0d_word%0d(spur=%0d): got %0d expected %0d",
                             t, i, spur, tri_v[t][i], 3*t + i);
                end
            end
            vectors++;
            if (tri_col[t] !== 3'(t + 5) || hold_ax[t] !== 32'(3*t)) begin
                miscompares++;
                $display("FAIL strip_col%0d(spur=%0d): colour=%0d held_ax=%0d expected %0d %0d",
                         t, spur, tri_col[t], hold_ax[t], t + 5, 3*t);
            end
        end
        vectors++;
        if (mem_read_addr !== 32'd15) begin
            miscompares++;
            $display("FAIL strip_reads(spur=%0d): got %0d expected 15", spur, mem_read_addr);
        end
    endtask

    task automatic test_count_zero;
        int bad;
        bad = 0;
        @(negedge clock);
        start = 1'b1; strip = 1'b0; count = 32'd0;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done !== 1'b1 || draw_en !== 1'b0 || mem_read_addr !== 32'd0) bad++;
            @(negedge clock);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL count_zero: %0d bad cycles expected 0 (done=%b addr=%0d)", bad, done, mem_read_addr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        strip       = 1'b0;
        count       = 32'd0;
        draw_done   = 1'b0;
        reset       = 1'b0;
        test_reset();
        test_reset_mid_fetch();
        test_list();
        test_strip(1'b0);
        test_count_zero();
        test_strip(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tri_fetch_pipe.md
# tri_fetch_pipe

Triangle fetch stage directly downstream of the MVP transform: once `pipe_mesh_controller` pulses `draw_tri_pipe_start`, this block walks the transformed-vertex result memory. It assembles one triangle at a time (list or strip topology) and its colour. It hands each triangle to the rasteriser (`draw_triangle`) with a `draw_en`/`draw_done` handshake, and signals `done` back to the controller when all triangles are drawn.

## Interface
- `WIDTH`, 32: coordinate, address and count width.
- `COLOUR_WIDTH`, 3: colour width.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; returns block to idle.
- `start`  in  1  begin a frame; sampled only in S_IDLE.
- `strip`  in  1  1 = triangle strip, 0 = triangle list; latched at start.
- `count`  in  WIDTH  number of triangles; latched at start.
- `done`  out  1  high when in S_IDLE.
- `mem_read_addr`  out  WIDTH  word address into vertex result memory.
- `mem_read_data`  in  WIDTH  vertex word, valid 1 cycle after address.
- `mem_col_addr`  out  WIDTH  triangle index into colour memory.
- `mem_col_data`  in  COLOUR_WIDTH  colour, valid 1 cycle after address.
- `ax, ay, az, bx, by, bz, cx, cy, cz`  out  WIDTH each  registered triangle vertices.
- `colour`  out  COLOUR_WIDTH  registered triangle colour.
- `draw_en`  out  1  one-cycle pulse: triangle valid, rasteriser start.
- `draw_done`  in  1  rasteriser finished current triangle.

## Operation
- Memory layout: vertex v occupies words 3v (x), 3v+1 (y), 3v+2 (z). The read address is a single word counter `wa`, starting at 0 and +1 per issued read. Both modes read memory strictly sequentially.
- Triangle index `ti` starts at 0. `mem_col_addr` = `ti` at all times.
- States:
  - S_IDLE: `done`=1. On `start`, latch `strip`/`count` and clear `wa` and `ti`.
    - If `count`=0, stay in S_IDLE.
    - Otherwise go to S_FETCH with the fetch length N=9.
  - S_FETCH: drive `mem_read_addr`=`wa` and increment `wa` each cycle, for N cycles. Each word returned (one cycle later) is written to the slot/field given by its position: word j → vertex j/3, field j%3. For N=3, the target is vertex c.
  - S_LAST: one cycle. Capture the final word and `mem_col_data` into `colour`.
  - S_DRAW: one cycle, `draw_en`=1.
  - S_WAIT_DRAW: hold until `draw_done`=1. Then:
    - If `ti`+1 = `count`, go to S_IDLE.
    - Otherwise increment `ti` and go to S_FETCH. In list mode N=9. In strip mode N=3, and on this transition a←b, b←c.
- Strip vertex order is not reversed for odd triangles. Winding is the rasteriser's concern.
- `ax`..`cz` and `colour` are held constant from the S_DRAW cycle until the S_WAIT_DRAW exit.
- `draw_done` is ignored outside S_WAIT_DRAW. `start` is ignored outside S_IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. `wa` wraps silently. Frames that need more than 2^WIDTH words are out of scope.
- Strip with `count`=1 is equivalent to list with `count`=1.

## Timing
- Reset values:
  - `done`=1, `draw_en`=0.
  - `mem_read_addr`=0, `mem_col_addr`=0.
  - All coordinates 0, `colour`=0.
  - State S_IDLE.
- Reset asserted mid-frame aborts immediately (asynchronous). Any `draw_done` is then ignored. The next `start` restarts from word 0.
- Cycle 0 = the cycle in which `start`=1 is sampled in S_IDLE.
  - First triangle: S_FETCH cycles 1–9 (addresses 0–8), S_LAST cycle 10, `draw_en` high in cycle 11.
- Cycle D = the cycle in which `draw_done`=1 is sampled.
  - Next list triangle: `draw_en` at D+11.
  - Next strip triangle: S_FETCH D+1..D+3, S_LAST D+4, `draw_en` at D+5.
- `done` falls in cycle 1. It rises the cycle after the final `draw_done`.
- `count`=0: `done` stays high continuously, and no read or `draw_en` occurs.
- The rasteriser must deassert `draw_done` by the cycle after `draw_en`.

## Test plan
- Reset mid-fetch:
  - Stimulus: assert `reset` during S_FETCH of triangle 0, then issue a fresh `start`.
  - Response: immediately `done`=1, `draw_en`=0, `mem_read_addr`=0; the fresh `start` re-reads from address 0.
- List, `count`=2:
  - Memory word k = k, colour[i] = i+5. Rasteriser returns `draw_done` 4 cycles after `draw_en`.
  - `draw_en` in cycle 11 with a=(0,1,2), b=(3,4,5), c=(6,7,8), `colour`=5.
  - Second `draw_en` with a=(9,10,11), `colour`=6.
  - `done` rises after the second `draw_done`.
- Strip, `count`=3, same memory:
  - Triangles: (0,1,2)/(3,4,5)/(6,7,8), then (3,4,5)/(6,7,8)/(9,10,11), then (6,7,8)/(9,10,11)/(12,13,14).
  - Each later `draw_en` comes exactly 5 cycles after `draw_done`.
  - Exactly 15 reads in total.
- `count`=0 with `start`: `done` never falls; no memory reads and no `draw_en`.
- Spurious inputs:
  - `start` pulsed during S_WAIT_DRAW, and `draw_done` held high during S_FETCH.
  - Response: both are ignored; the triangle sequence and cycle counts are identical to the clean run.
